// File: rtl/dual_port_latency_ram.sv
// Dual-port RAM with independent, fixed, per-port write and read latencies.
// Writes travel down a per-port pipeline and commit late. Reads sample the
// array read-first at the request edge and then ride a delay line to the port.

// Fixed-length valid/payload delay line with synchronous clear.
// STAGES = 0 passes the input straight through. At least one register is
// always built so that clk is never left dangling.
module dpl_pipe #(
  parameter int STAGES = 1,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  localparam int N = (STAGES < 1) ? 1 : STAGES;

  logic [N-1:0]        vld_q, vld_d;
  logic [N-1:0][W-1:0] dat_q, dat_d;

  // Shift the valid bit and payload one stage per cycle.
  always_comb begin
    vld_d[0] = in_vld;
    dat_d[0] = in_data;
    for (int i = 1; i < N; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // A zero-stage line is a plain wire. Otherwise take the last register.
  always_comb begin
    if (STAGES == 0) begin
      out_vld  = in_vld;
      out_data = in_data;
    end else begin
      out_vld  = vld_q[N-1];
      out_data = dat_q[N-1];
    end
  end
endmodule

module dual_port_latency_ram #(
  parameter int DATA_WIDTH  = 4,
  parameter int MEM_DEPTH   = 16,
  parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
  parameter int WR_LATENCYA = 10,
  parameter int RD_LATENCYA = 5,
  parameter int WR_LATENCYB = 7,
  parameter int RD_LATENCYB = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  wr_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  en_b,
  input  logic                  wr_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  output logic                  wcollision
);
  if (WR_LATENCYA < 1 || WR_LATENCYA > 16 || RD_LATENCYA < 1 || RD_LATENCYA > 16 ||
      WR_LATENCYB < 1 || WR_LATENCYB > 16 || RD_LATENCYB < 1 || RD_LATENCYB > 16) begin : g_bad_latency
    $error("dual_port_latency_ram: every latency must lie in 1..16");
  end

  localparam int AW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
  logic                  wcol_q, wcol_d;

  logic                  cma_vld, cmb_vld;
  logic [AW-1:0]         cma_pl, cmb_pl;
  logic [ADDR_WIDTH-1:0] cma_addr, cmb_addr;
  logic [DATA_WIDTH-1:0] cma_data, cmb_data;
  logic [DATA_WIDTH-1:0] rword_a, rword_b, rpipe_a, rpipe_b;
  logic                  rvld_a, rvld_b;

  // A write sampled at edge t reaches the commit point WR_LATENCY-1 edges later.
  dpl_pipe #(.STAGES(WR_LATENCYA - 1), .W(AW)) u_wpipe_a (
    .clk(clk), .rst(rst), .in_vld(en_a & wr_a), .in_data({addr_a, wdata_a}),
    .out_vld(cma_vld), .out_data(cma_pl));
  dpl_pipe #(.STAGES(WR_LATENCYB - 1), .W(AW)) u_wpipe_b (
    .clk(clk), .rst(rst), .in_vld(en_b & wr_b), .in_data({addr_b, wdata_b}),
    .out_vld(cmb_vld), .out_data(cmb_pl));

  assign {cma_addr, cma_data} = cma_pl;
  assign {cmb_addr, cmb_data} = cmb_pl;

  // Read-first sampling: the array contents before this edge's commits.
  // Out-of-range addresses read as zero.
  always_comb begin
    rword_a = '0;
    rword_b = '0;
    if (in_range(addr_a)) rword_a = mem_q[addr_a];
    if (in_range(addr_b)) rword_b = mem_q[addr_b];
  end

  dpl_pipe #(.STAGES(RD_LATENCYA), .W(DATA_WIDTH)) u_rpipe_a (
    .clk(clk), .rst(rst), .in_vld(en_a & ~wr_a), .in_data(rword_a),
    .out_vld(rvld_a), .out_data(rpipe_a));
  dpl_pipe #(.STAGES(RD_LATENCYB), .W(DATA_WIDTH)) u_rpipe_b (
    .clk(clk), .rst(rst), .in_vld(en_b & ~wr_b), .in_data(rword_b),
    .out_vld(rvld_b), .out_data(rpipe_b));

  // Commit both ports. A is applied last so that it wins a same-address clash.
  always_comb begin
    mem_d = mem_q;
    if (cmb_vld && in_range(cmb_addr)) mem_d[cmb_addr] = cmb_data;
    if (cma_vld && in_range(cma_addr)) mem_d[cma_addr] = cma_data;
    wcol_d = cma_vld & cmb_vld & in_range(cma_addr) & (cma_addr == cmb_addr);
  end

  // Array and collision flag. Reset clears every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      wcol_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wcol_q <= wcol_d;
    end
  end

  assign rvalid_a   = rvld_a;
  assign rvalid_b   = rvld_b;
  assign rdata_a    = rvld_a ? rpipe_a : '0;
  assign rdata_b    = rvld_b ? rpipe_b : '0;
  assign wcollision = wcol_q;
endmodule

// File: tb/tb_dual_port_latency_ram.sv
// Randomised bench for dual_port_latency_ram with a cycle-indexed reference
// model, plus directed scenarios with literal expectations. A second instance
// with MEM_DEPTH = 12 covers out-of-range addresses.
module tb_dual_port_latency_ram;
  localparam int WLA = 10, RLA = 5, WLB = 7, RLB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a = 0, wr_a = 0, en_b = 0, wr_b = 0;
  logic [3:0] addr_a = 0, wdata_a = 0, addr_b = 0, wdata_b = 0;
  logic [3:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b, wcollision;

  logic       s_en_a = 0, s_wr_a = 0, s_en_b = 0, s_wr_b = 0;
  logic [3:0] s_addr_a = 0, s_wdata_a = 0, s_addr_b = 0, s_wdata_b = 0;
  logic [3:0] s_rdata_a, s_rdata_b;
  logic       s_rvalid_a, s_rvalid_b, s_wcol;

  dual_port_latency_ram u_dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .wcollision(wcollision));

  dual_port_latency_ram #(.MEM_DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst),
    .en_a(s_en_a), .wr_a(s_wr_a), .addr_a(s_addr_a), .wdata_a(s_wdata_a),
    .en_b(s_en_b), .wr_b(s_wr_b), .addr_b(s_addr_b), .wdata_b(s_wdata_b),
    .rdata_a(s_rdata_a), .rvalid_a(s_rvalid_a), .rdata_b(s_rdata_b), .rvalid_b(s_rvalid_b),
    .wcollision(s_wcol));

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, tcyc, act, exp);
    end
  endtask

  // Reference model: memory image plus rings indexed by absolute cycle number.
  // Edge k samples the inputs of cycle k; the outputs after edge k belong to cycle k+1.
  bit [3:0] m_mem [16];
  bit       xa_v [64], xb_v [64], xcol [64];
  bit [3:0] xa_d [64], xb_d [64];
  bit       pa_v [64], pb_v [64];
  bit [3:0] pa_a [64], pa_d [64], pb_a [64], pb_d [64];
  int       ecnt = 0;

  always @(posedge clk) begin
    int  s;
    bit  ca, cb;
    bit [3:0] caa, cad, cba, cbd;
    s = ecnt % 64;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      for (int i = 0; i < 64; i++) begin
        xa_v[i] = 0; xb_v[i] = 0; xcol[i] = 0; xa_d[i] = 0; xb_d[i] = 0;
        pa_v[i] = 0; pb_v[i] = 0;
      end
    end else begin
      xa_v[s] = 0; xb_v[s] = 0; xcol[s] = 0; xa_d[s] = 0; xb_d[s] = 0;
      if (en_a && !wr_a) begin
        xa_v[(ecnt + RLA) % 64] = 1; xa_d[(ecnt + RLA) % 64] = m_mem[addr_a];
      end
      if (en_b && !wr_b) begin
        xb_v[(ecnt + RLB) % 64] = 1; xb_d[(ecnt + RLB) % 64] = m_mem[addr_b];
      end
      if (en_a && wr_a) begin
        pa_v[(ecnt + WLA - 1) % 64] = 1; pa_a[(ecnt + WLA - 1) % 64] = addr_a;
        pa_d[(ecnt + WLA - 1) % 64] = wdata_a;
      end
      if (en_b && wr_b) begin
        pb_v[(ecnt + WLB - 1) % 64] = 1; pb_a[(ecnt + WLB - 1) % 64] = addr_b;
        pb_d[(ecnt + WLB - 1) % 64] = wdata_b;
      end
      ca = pa_v[s]; caa = pa_a[s]; cad = pa_d[s]; pa_v[s] = 0;
      cb = pb_v[s]; cba = pb_a[s]; cbd = pb_d[s]; pb_v[s] = 0;
      if (cb) m_mem[cba] = cbd;
      if (ca) m_mem[caa] = cad;
      if (ca && cb && caa == cba) xcol[(ecnt + 1) % 64] = 1;
    end
    ecnt++;
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    int s;
    s = ecnt % 64;
    if (chk_en) begin
      chk("model rvalid_a", 32'(rvalid_a), 32'(xa_v[s]));
      chk("model rdata_a", 32'(rdata_a), 32'(xa_d[s]));
      chk("model rvalid_b", 32'(rvalid_b), 32'(xb_v[s]));
      chk("model rdata_b", 32'(rdata_b), 32'(xb_d[s]));
      chk("model wcollision", 32'(wcollision), 32'(xcol[s]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
    en_a = 0; en_b = 0; s_en_a = 0;
  endtask

  task automatic goto(input int c);
    while (tcyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    tcyc = 0;
  endtask

  task automatic rd_a(input logic [3:0] a);
    en_a = 1; wr_a = 0; addr_a = a;
  endtask
  task automatic wr_a_t(input logic [3:0] a, input logic [3:0] d);
    en_a = 1; wr_a = 1; addr_a = a; wdata_a = d;
  endtask
  task automatic rd_b(input logic [3:0] a);
    en_b = 1; wr_b = 0; addr_b = a;
  endtask
  task automatic wr_b_t(input logic [3:0] a, input logic [3:0] d);
    en_b = 1; wr_b = 1; addr_b = a; wdata_b = d;
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    chk("reset rvalid_a", 32'(rvalid_a), 0);
    chk("reset rvalid_b", 32'(rvalid_b), 0);
    chk("reset rdata_a", 32'(rdata_a), 0);
    chk("reset rdata_b", 32'(rdata_b), 0);
    chk("reset wcollision", 32'(wcollision), 0);

    // Read A addr 3 at cycle 0: rvalid_a in cycle 5 only, data 0.
    rd_a(4'd3);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("rd latency rvalid_a", 32'(rvalid_a), (c == 5) ? 32'd1 : 32'd0);
    end
    chk("rd latency rdata_a", 32'(rdata_a), 0);

    // Read-first at the commit edge.
    do_reset();
    wr_a_t(4'd2, 4'hA);
    goto(9);  rd_b(4'd2);
    goto(10); rd_b(4'd2);
    goto(17);
    chk("read-first rvalid_b", 32'(rvalid_b), 1);
    chk("read-first old rdata_b", 32'(rdata_b), 0);
    goto(18);
    chk("read-first new rdata_b", 32'(rdata_b), 32'hA);

    // Same-address collision on E_9: A wins, flag in cycle 10 only.
    do_reset();
    wr_a_t(4'd5, 4'h3);
    goto(3); wr_b_t(4'd5, 4'h6);
    goto(9);  chk("collision before", 32'(wcollision), 0);
    goto(10); chk("collision pulse", 32'(wcollision), 1);
    goto(11); chk("collision after", 32'(wcollision), 0);
    rd_a(4'd5);
    goto(16); chk("collision winner", 32'(rdata_a), 32'h3);

    // A reset in flight discards the pending write.
    do_reset();
    wr_a_t(4'd1, 4'hF);
    goto(4);
    rst = 1;
    step();
    rst = 0;
    tcyc = 0;
    chk("mid reset rvalid_a", 32'(rvalid_a), 0);
    goto(8); rd_a(4'd1);
    goto(13);
    chk("mid reset read rvalid_a", 32'(rvalid_a), 1);
    chk("mid reset read rdata_a", 32'(rdata_a), 0);

    // Back-to-back reads on B while A runs random traffic.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_b_t(4'(i), 4'(i + 1));
      step();
    end
    goto(20);
    for (int i = 0; i < 8; i++) begin
      rd_b(4'(i));
      en_a = 1; wr_a = 1'($urandom_range(0, 1)); addr_a = 4'($urandom_range(8, 15));
      wdata_a = 4'($urandom_range(0, 15));
      step();
    end
    goto(28);
    for (int i = 0; i < 8; i++) begin
      chk("burst rvalid_b", 32'(rvalid_b), 1);
      chk("burst rdata_b", 32'(rdata_b), 32'(i + 1));
      step();
    end
    chk("burst end rvalid_b", 32'(rvalid_b), 0);

    // MEM_DEPTH = 12 instance: out-of-range write is dropped, in-range works.
    do_reset();
    s_en_a = 1; s_wr_a = 1; s_addr_a = 4'd13; s_wdata_a = 4'h5;
    step();
    s_en_a = 1; s_wr_a = 1; s_addr_a = 4'd11; s_wdata_a = 4'h9;
    goto(15); s_en_a = 1; s_wr_a = 0; s_addr_a = 4'd13;
    goto(16); s_en_a = 1; s_wr_a = 0; s_addr_a = 4'd11;
    goto(20);
    chk("depth12 oor rvalid", 32'(s_rvalid_a), 1);
    chk("depth12 oor rdata", 32'(s_rdata_a), 0);
    goto(21);
    chk("depth12 in-range rdata", 32'(s_rdata_a), 32'h9);
    chk("depth12 no collision", 32'(s_wcol), 0);

    // Random traffic. Half the addresses come from a narrow range to provoke collisions.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      en_a = 1'($urandom_range(0, 1)); wr_a = 1'($urandom_range(0, 1));
      addr_a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wdata_a = 4'($urandom_range(0, 15));
      en_b = 1'($urandom_range(0, 1)); wr_b = 1'($urandom_range(0, 1));
      addr_b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wdata_b = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    goto(tcyc + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_latency_ram.md
DUAL_PORT_LATENCY_RAM -- requirements
Module: dual_port_latency_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of a stored word and of wdata/rdata.
REQ-002 Parameter MEM_DEPTH, default 16: number of words; need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH): address width of both ports.
REQ-004 Parameters WR_LATENCYA / RD_LATENCYA / WR_LATENCYB / RD_LATENCYB, defaults 10 / 5 / 7 / 8: per-port write and read latency in cycles; each legal range 1..16; out of range SHALL be an elaboration error.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en_a / en_b  input  1  request strobe for port A / B; one request accepted per port per cycle while high.
REQ-008 wr_a / wr_b  input  1  1 = write request, 0 = read request; ignored when en is low.
REQ-009 addr_a / addr_b  input  ADDR_WIDTH  word address.
REQ-010 wdata_a / wdata_b  input  DATA_WIDTH  write data.
REQ-011 rdata_a / rdata_b  output  DATA_WIDTH  read data, meaningful only while rvalid is high.
REQ-012 rvalid_a / rvalid_b  output  1  one-cycle pulse marking returned read data.
REQ-013 wcollision  output  1  one-cycle pulse: both ports committed writes to the same address on the same edge.

Function
REQ-014 A request presented in cycle t SHALL be sampled at edge E_t; no backpressure, requests never stall.
REQ-015 Write sampled at E_t SHALL commit to the array at edge E_(t+WR_LATENCYx-1); address and data carried through a per-port pipeline of WR_LATENCYx stages.
REQ-016 A read sampled at E_t SHALL read the array as it was before E_t (read-first) and SHALL present rdata with rvalid high during cycle t+RD_LATENCYx only.
REQ-017 Reads accepted every cycle SHALL return every cycle, in issue order, with fixed latency; pipelines fully independent per port.
REQ-018 Write commit and read sample on the same address at the same edge: read SHALL return the old word; no flag.
REQ-019 Both ports committing to the same address at the same edge: port A data SHALL win; wcollision high during the following cycle.
REQ-020 Both ports committing to different addresses at the same edge: both SHALL commit.
REQ-021 Address >= MEM_DEPTH: write SHALL be discarded at commit; read SHALL return 0 with normal rvalid timing; never flags a collision.
REQ-022 rdata SHALL be 0 in any cycle where rvalid is low.
REQ-023 A read and a write on one port cannot coincide (wr selects one); the two ports may issue any mix simultaneously.

Reset
REQ-024 While rst is high at an edge: all array words cleared to 0; all write and read pipeline stages invalidated (in-flight requests discarded, never commit or return); requests in that cycle ignored.
REQ-025 Outputs in the cycle after a reset edge: rdata_a = rdata_b = 0, rvalid_a = rvalid_b = 0, wcollision = 0.
REQ-026 First request accepted at the first edge with rst low; timing per REQ-015/016 from that edge.

Verification (default parameters, cycle 0 = first cycle after reset deasserts)
REQ-027 Read A addr 3 in cycle 0 -> rvalid_a high in cycle 5 only, rdata_a = 0.
REQ-028 Write A addr 2 data 0xA cycle 0; read B addr 2 cycles 9 and 10 -> rdata_b = 0x0 in cycle 17, 0xA in cycle 18.
REQ-029 Write A addr 5 data 0x3 cycle 0, write B addr 5 data 0x6 cycle 3 (both commit E_9) -> wcollision high cycle 10 only; later read of addr 5 returns 0x3.
REQ-030 Write A addr 1 data 0xF cycle 0, rst high cycle 4, release; read A addr 1 -> returns 0, no stray rvalid or wcollision from pre-reset traffic.
REQ-031 Port B reads addr 0..7 in cycles 0..7 after writing 0x1..0x8 there -> rvalid_b high cycles 8..15 continuously, data 0x1..0x8 in order; port A traffic in parallel unaffected.
REQ-032 MEM_DEPTH = 12: write addr 13 data 0x5 then read addr 13 -> read returns 0; addr 11 write/read returns written value.
